// File: rtl/io_bus_arbiter_if.sv
// Requester-side and I/O-bus signals of io_bus_arbiter, grouped for port hookup.
// master is the arbiter's view; slave is the view of the requesters plus the bus device.
interface io_bus_arbiter_if;
  logic        req0, req1;
  logic        wr0, wr1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        ack0, ack1;
  logic [7:0]  rdata;
  logic [15:0] addr;
  logic        ior_, iow_;

  modport master (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata, addr, ior_, iow_
  );

  modport slave (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata, addr, ior_, iow_
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// Two-requester round-robin arbiter running fixed-timing read/write cycles
// on an 8-bit I/O bus with active-low strobes.
module io_bus_arbiter #(
  parameter int unsigned STROBE_CLOCKS = 2,
  parameter logic [15:0] IDLE_ADDR     = 16'hFFFF
) (
  input  logic               clock,
  input  logic               reset,
  io_bus_arbiter_if.master   bus,
  inout  wire  [7:0]         data
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, ACK} state_e;

  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CLOCKS - 1);

  state_e      state_q;
  logic        gnt_q;      // requester owning the current transaction
  logic        last_q;     // requester granted most recently
  logic        wr_q;
  logic [7:0]  wdata_q;
  logic [3:0]  cnt_q;
  logic        drive_q;
  logic [15:0] addr_q;
  logic        ior_q, iow_q;
  logic        ack0_q, ack1_q;
  logic [7:0]  rdata_q;
  logic        grant_d;

  // On a tie the requester not granted last wins; a lone request always wins.
  always_comb begin
    grant_d = bus.req1;
    if (bus.req0 && bus.req1) grant_d = ~last_q;
  end

  // NOTE: every bus output is a flop with an async reset value, so asserting
  // reset parks the bus immediately without waiting for a clock edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      wr_q    <= 1'b0;
      wdata_q <= 8'h00;
      cnt_q   <= 4'd0;
      drive_q <= 1'b0;
      addr_q  <= IDLE_ADDR;
      ior_q   <= 1'b1;
      iow_q   <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      // NOTE: acks default low here and are raised later in the same block;
      // the last non-blocking assignment wins, giving a one-clock pulse.
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            gnt_q   <= grant_d;
            last_q  <= grant_d;
            wr_q    <= grant_d ? bus.wr1    : bus.wr0;
            wdata_q <= grant_d ? bus.wdata1 : bus.wdata0;
            addr_q  <= grant_d ? bus.addr1  : bus.addr0;
            drive_q <= grant_d ? bus.wr1    : bus.wr0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          ior_q   <= wr_q;
          iow_q   <= ~wr_q;
          cnt_q   <= STROBE_LAST;
          state_q <= STROBE;
        end
        STROBE: begin
          if (cnt_q == 4'd0) begin
            ior_q   <= 1'b1;
            iow_q   <= 1'b1;
            if (!wr_q) rdata_q <= data;
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        HOLD: begin
          addr_q  <= IDLE_ADDR;
          drive_q <= 1'b0;
          ack0_q  <= ~gnt_q;
          ack1_q  <= gnt_q;
          state_q <= ACK;
        end
        ACK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data     = drive_q ? wdata_q : 8'hzz;
  assign bus.addr = addr_q;
  assign bus.ior_ = ior_q;
  assign bus.iow_ = iow_q;
  assign bus.ack0 = ack0_q;
  assign bus.ack1 = ack1_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: a table of transactions with hand-computed
// expectations, plus reset-abort and STROBE_CLOCKS=4 sequences.
module tb_io_bus_arbiter;
  localparam int N  = 2;
  localparam int N4 = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  io_bus_arbiter_if u_if ();
  io_bus_arbiter_if u_if4 ();

  wire  [7:0] data, data4;
  logic       dev_en, dev_en4;
  logic [7:0] dev_q, dev_q4;

  // Bus device: drives 8'h00 when idle so a stray arbiter drive shows up.
  assign data  = dev_en  ? dev_q  : 8'hzz;
  assign data4 = dev_en4 ? dev_q4 : 8'hzz;

  io_bus_arbiter #(.STROBE_CLOCKS(N), .IDLE_ADDR(16'hFFFF)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if.master),
    .data  (data)
  );

  io_bus_arbiter #(.STROBE_CLOCKS(N4), .IDLE_ADDR(16'hFFFF)) u_dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (u_if4.master),
    .data  (data4)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        req0, req1, wr0, wr1;
    logic [15:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1, dev;
    logic        mangle;     // alter inputs one clock after grant
    logic        exp_gnt, exp_wr;
    logic [15:0] exp_addr;
    logic [7:0]  exp_wdata, exp_rdata;
  } vec_t;

  function automatic vec_t mk(input logic r0, input logic r1, input logic w0, input logic w1,
                              input logic [15:0] a0, input logic [15:0] a1,
                              input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] dv,
                              input logic mg, input logic g, input logic ew,
                              input logic [15:0] ea, input logic [7:0] ed, input logic [7:0] er);
    vec_t v;
    v.req0 = r0; v.req1 = r1; v.wr0 = w0; v.wr1 = w1;
    v.addr0 = a0; v.addr1 = a1; v.wdata0 = d0; v.wdata1 = d1; v.dev = dv;
    v.mangle = mg; v.exp_gnt = g; v.exp_wr = ew;
    v.exp_addr = ea; v.exp_wdata = ed; v.exp_rdata = er;
    return v;
  endfunction

  vec_t       vecs [10];
  logic [7:0] exp_prev;

  // Caller sits 1 time unit after a rising edge with the DUT in IDLE; the next
  // edge is the grant. k counts edges after the grant: ack is high after edge
  // N+2 and is therefore seen by the requester on edge N+3.
  task automatic run_txn(input vec_t v, input int idx);
    logic [7:0]  prev;
    logic [15:0] e_addr;
    logic        e_ior, e_iow, e_ack0, e_ack1;
    logic [7:0]  e_data, e_rd;
    prev = exp_prev;
    u_if.req0 = v.req0;     u_if.req1 = v.req1;
    u_if.wr0 = v.wr0;       u_if.wr1 = v.wr1;
    u_if.addr0 = v.addr0;   u_if.addr1 = v.addr1;
    u_if.wdata0 = v.wdata0; u_if.wdata1 = v.wdata1;
    dev_q = v.dev;
    dev_en = ~v.exp_wr;
    for (int k = 0; k <= N + 3; k++) begin
      @(posedge clock); #1;
      if (k == 0 && v.mangle) begin
        u_if.addr0  = u_if.addr0 ^ 16'h0001;
        u_if.wdata0 = ~u_if.wdata0;
        u_if.wr0    = ~u_if.wr0;
        u_if.req0   = 1'b0;
      end
      if (k == N + 2 && v.exp_wr) begin
        dev_en = 1'b1;
        dev_q  = 8'h00;
        #1;
      end
      e_addr = (k <= N + 1) ? v.exp_addr : 16'hFFFF;
      e_ior  = !(k >= 1 && k <= N && !v.exp_wr);
      e_iow  = !(k >= 1 && k <= N && v.exp_wr);
      e_ack0 = (k == N + 2) && !v.exp_gnt;
      e_ack1 = (k == N + 2) && v.exp_gnt;
      e_data = v.exp_wr ? ((k <= N + 1) ? v.exp_wdata : 8'h00) : v.dev;
      e_rd   = (k <= N) ? prev : v.exp_rdata;
      check($sformatf("v%0d k%0d addr", idx, k),  u_if.addr,  e_addr);
      check($sformatf("v%0d k%0d ior_", idx, k),  u_if.ior_,  e_ior);
      check($sformatf("v%0d k%0d iow_", idx, k),  u_if.iow_,  e_iow);
      check($sformatf("v%0d k%0d ack0", idx, k),  u_if.ack0,  e_ack0);
      check($sformatf("v%0d k%0d ack1", idx, k),  u_if.ack1,  e_ack1);
      check($sformatf("v%0d k%0d data", idx, k),  data,       e_data);
      check($sformatf("v%0d k%0d rdata", idx, k), u_if.rdata, e_rd);
    end
    exp_prev = v.exp_rdata;
  endtask

  initial begin
    //              r0 r1 w0 w1 addr0     addr1     wd0    wd1    dev   mg gnt wr exp_addr  exp_wd exp_rd
    vecs[0] = mk(1, 0, 0, 0, 16'h0120, 16'h0000, 8'h00, 8'h00, 8'h2A, 0, 0, 0, 16'h0120, 8'h00, 8'h2A);
    vecs[1] = mk(0, 1, 0, 1, 16'h0000, 16'h0140, 8'h00, 8'h5C, 8'h00, 0, 1, 1, 16'h0140, 8'h5C, 8'h2A);
    vecs[2] = mk(1, 1, 0, 1, 16'h0200, 16'h0210, 8'h00, 8'h11, 8'h3C, 0, 0, 0, 16'h0200, 8'h00, 8'h3C);
    vecs[3] = mk(1, 1, 0, 1, 16'h0200, 16'h0210, 8'h00, 8'h11, 8'h00, 0, 1, 1, 16'h0210, 8'h11, 8'h3C);
    vecs[4] = mk(1, 1, 0, 1, 16'h0200, 16'h0210, 8'h00, 8'h11, 8'h4D, 0, 0, 0, 16'h0200, 8'h00, 8'h4D);
    vecs[5] = mk(1, 1, 0, 1, 16'h0200, 16'h0210, 8'h00, 8'h11, 8'h00, 0, 1, 1, 16'h0210, 8'h11, 8'h4D);
    vecs[6] = mk(0, 1, 0, 0, 16'h0000, 16'h0300, 8'h00, 8'h00, 8'h77, 0, 1, 0, 16'h0300, 8'h00, 8'h77);
    vecs[7] = mk(1, 0, 1, 0, 16'h0100, 16'h0000, 8'hA5, 8'h00, 8'h00, 1, 0, 1, 16'h0100, 8'hA5, 8'h77);
    vecs[8] = mk(1, 1, 0, 1, 16'h0400, 16'h0410, 8'h00, 8'h33, 8'h00, 0, 1, 1, 16'h0410, 8'h33, 8'h77);
    vecs[9] = mk(1, 0, 0, 0, 16'h0500, 16'h0000, 8'h00, 8'h00, 8'hE1, 0, 0, 0, 16'h0500, 8'h00, 8'hE1);

    reset = 1'b1;
    u_if.req0 = 0; u_if.req1 = 0; u_if.wr0 = 0; u_if.wr1 = 0;
    u_if.addr0 = 0; u_if.addr1 = 0; u_if.wdata0 = 0; u_if.wdata1 = 0;
    u_if4.req0 = 0; u_if4.req1 = 0; u_if4.wr0 = 0; u_if4.wr1 = 0;
    u_if4.addr0 = 0; u_if4.addr1 = 0; u_if4.wdata0 = 0; u_if4.wdata1 = 0;
    dev_en = 1'b1;  dev_q = 8'h00;
    dev_en4 = 1'b1; dev_q4 = 8'h00;

    #1;
    check("rst addr",  u_if.addr,  16'hFFFF);
    check("rst ior_",  u_if.ior_,  1'b1);
    check("rst iow_",  u_if.iow_,  1'b1);
    check("rst ack0",  u_if.ack0,  1'b0);
    check("rst ack1",  u_if.ack1,  1'b0);
    check("rst rdata", u_if.rdata, 8'h00);
    check("rst data",  data,       8'h00);
    check("rst addr4", u_if4.addr, 16'hFFFF);

    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    check("idle addr", u_if.addr, 16'hFFFF);
    check("idle ior_", u_if.ior_, 1'b1);

    exp_prev = 8'h00;
    for (int i = 0; i < 10; i++) run_txn(vecs[i], i);

    u_if.req0 = 1'b0; u_if.req1 = 1'b0;
    dev_en = 1'b1; dev_q = 8'h00;
    for (int k = 0; k < 2; k++) begin
      @(posedge clock); #1;
      check($sformatf("idle%0d addr", k), u_if.addr, 16'hFFFF);
      check($sformatf("idle%0d strb", k), {u_if.ior_, u_if.iow_}, 2'b11);
      check($sformatf("idle%0d data", k), data, 8'h00);
      check($sformatf("idle%0d rdata", k), u_if.rdata, 8'hE1);
    end

    // Reset in the middle of a write strobe.
    u_if.req0 = 1'b1; u_if.wr0 = 1'b1; u_if.addr0 = 16'h0600; u_if.wdata0 = 8'hC3;
    dev_en = 1'b0;
    @(posedge clock); #1;
    check("rmid setup data", data, 8'hC3);
    @(posedge clock); #1;
    check("rmid strobe iow_", u_if.iow_, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("rmid iow_",  u_if.iow_,  1'b1);
    check("rmid ior_",  u_if.ior_,  1'b1);
    check("rmid addr",  u_if.addr,  16'hFFFF);
    check("rmid ack0",  u_if.ack0,  1'b0);
    check("rmid rdata", u_if.rdata, 8'h00);
    dev_en = 1'b1; dev_q = 8'h00;
    #1;
    check("rmid data", data, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      check($sformatf("rhold%0d ack0", k), u_if.ack0, 1'b0);
    end
    u_if.req0 = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    check("rrel ack0", u_if.ack0, 1'b0);
    check("rrel addr", u_if.addr, 16'hFFFF);
    exp_prev = 8'h00;
    // Tie right after reset: requester 0 must win again.
    run_txn(mk(1, 1, 0, 1, 16'h0700, 16'h0710, 8'h00, 8'h22, 8'h5E, 0, 0, 0, 16'h0700, 8'h00, 8'h5E), 10);

    // STROBE_CLOCKS = 4 instance: single read.
    u_if4.req0 = 1'b1; u_if4.wr0 = 1'b0; u_if4.addr0 = 16'h0120;
    dev_q4 = 8'h2A;
    for (int k = 0; k <= N4 + 3; k++) begin
      @(posedge clock); #1;
      check($sformatf("s4 k%0d ior_", k),  u_if4.ior_,  !(k >= 1 && k <= N4));
      check($sformatf("s4 k%0d iow_", k),  u_if4.iow_,  1'b1);
      check($sformatf("s4 k%0d ack0", k),  u_if4.ack0,  k == N4 + 2);
      check($sformatf("s4 k%0d addr", k),  u_if4.addr,  (k <= N4 + 1) ? 16'h0120 : 16'hFFFF);
      check($sformatf("s4 k%0d rdata", k), u_if4.rdata, (k >= N4 + 1) ? 8'h2A : 8'h00);
    end
    u_if4.req0 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 Parameter STROBE_CLOCKS, default 2, number of clocks ior_/iow_ is held low per bus cycle (legal 1..15).
REQ-002 Parameter IDLE_ADDR, default 16'hFFFF, address driven while no bus cycle is in progress.
REQ-003 clock  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset  in  1  reset, asynchronous and active-high.
REQ-005 req0, req1  in  1 each  level request from requester 0/1; held high until the matching ack.
REQ-006 wr0, wr1  in  1 each  1 = write cycle, 0 = read cycle; valid while req is high.
REQ-007 addr0, addr1  in  16 each  I/O address of the requested cycle.
REQ-008 wdata0, wdata1  in  8 each  write data.
REQ-009 ack0, ack1  out  1 each  one-clock completion pulse to requester 0/1.
REQ-010 rdata  out  8  data returned by the most recent completed read cycle.
REQ-011 addr  out  16  I/O bus address.
REQ-012 data  inout  8  I/O bus data; tri-stated unless the block drives a write.
REQ-013 ior_, iow_  out  1 each  active-low read/write strobes.

Function
REQ-014 FSM states IDLE, SETUP, STROBE, HOLD, ACK; one transaction is one pass IDLE->SETUP->STROBE->HOLD->ACK->IDLE.
REQ-015 IDLE: with no req high, stay IDLE; addr=IDLE_ADDR, ior_=iow_=1, data=Z.
REQ-016 IDLE with any req high: grant one requester, latch its wr/addr/wdata into internal registers on the same edge, go to SETUP.
REQ-017 Arbitration round-robin: with both req high, grant the requester not granted last; after reset requester 0 wins the first tie.
REQ-018 With a single req high, grant it regardless of round-robin pointer; the pointer updates to the granted requester on every grant.
REQ-019 SETUP lasts exactly 1 clock: addr=latched address, strobes high, data driven with latched wdata if write, Z if read.
REQ-020 STROBE lasts exactly STROBE_CLOCKS clocks via an internal counter: ior_=0 for read or iow_=0 for write, never both.
REQ-021 Read: rdata loads from data on the rising edge that ends STROBE.
REQ-022 HOLD lasts exactly 1 clock: strobes high, addr and write data still driven.
REQ-023 ACK lasts exactly 1 clock: addr=IDLE_ADDR, data=Z, strobes high, ack of granted requester=1, other ack=0; next state IDLE.
REQ-024 Latency: req sampled high in IDLE -> ack high exactly STROBE_CLOCKS+3 clocks later; back-to-back transactions occupy STROBE_CLOCKS+4 clocks each.
REQ-025 Latched inputs are used for the whole transaction; changes to wr/addr/wdata or req after grant have no effect.
REQ-026 A req dropped mid-transaction does not abort it; the cycle completes and ack still pulses.
REQ-027 req still high in the IDLE clock after its ack is a new request.
REQ-028 rdata unchanged by write cycles and between transactions.
REQ-029 data is never driven in IDLE, ACK, or any read-cycle state.

Reset
REQ-030 reset high forces immediately, independent of clock: state IDLE, ior_=iow_=1, data=Z, addr=IDLE_ADDR, ack0=ack1=0, rdata=8'h00, round-robin pointer favouring requester 0, strobe counter 0.
REQ-031 reset asserted mid-transaction abandons it with no ack; the first request after release starts a fresh transaction.

Verification
REQ-032 Single read: req0=1, wr0=0, addr0=16'h0120, device drives 8'h2A -> ior_ low exactly 2 clocks, addr=16'h0120 during SETUP..HOLD, ack0 pulses 5 clocks after grant sample, rdata=8'h2A.
REQ-033 Single write: req1=1, wr1=1, addr1=16'h0140, wdata1=8'h5C -> iow_ low 2 clocks, data=8'h5C from SETUP through HOLD, Z otherwise, ack1 one pulse.
REQ-034 Simultaneous: req0=req1=1 held through both acks -> order 0,1,0,1; each transaction 6 clocks; strobes never overlap.
REQ-035 Latched inputs: change addr0 from 16'h0100 to 16'h0101 one clock after grant -> bus shows 16'h0100 for the whole transaction.
REQ-036 Reset mid-STROBE: assert reset during iow_=0 -> iow_=1, data=Z, addr=16'hFFFF without a clock edge; no ack; next request completes normally.
REQ-037 STROBE_CLOCKS=4 build: single read -> ior_ low exactly 4 clocks, ack 7 clocks after grant sample.
